// File: rtl/rr_req_encoder.sv
// ---------------------------------------------------------------------------
// rr_req_encoder
//   Round-robin request encoder. Collapses NUM_INPUTS request lines into one
//   registered binary index with a valid/ready handshake toward a single
//   consumer. The pointer holds the index where the round-robin search
//   starts. A grant stays fixed until the consumer accepts it.
//
//   Optional feature macro: RR_REQ_ENCODER_LOCK_EN
//     When defined, adds input i_lock. A handshake with i_lock=1 while the
//     granted requester is still requesting re-grants the same index and
//     leaves the pointer where it is (burst ownership).
// ---------------------------------------------------------------------------
module rr_req_encoder #(
  parameter int NUM_INPUTS = 5,
  localparam int IDX_BITS  = $clog2(NUM_INPUTS)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NUM_INPUTS-1:0] i_req,
  input  logic                  i_enable,
  input  logic                  i_ready,
`ifdef RR_REQ_ENCODER_LOCK_EN
  input  logic                  i_lock,
`endif
  output logic                  o_valid,
  output logic [IDX_BITS-1:0]   o_index,
  output logic [NUM_INPUTS-1:0] o_grant
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam logic [IDX_BITS-1:0] LAST_IDX = IDX_BITS'(NUM_INPUTS - 1);
  localparam logic [IDX_BITS:0]   N_WIDE   = (IDX_BITS + 1)'(NUM_INPUTS);

  state_t                  state;
  logic [IDX_BITS-1:0]     pointer;

  logic                    handshake;
  logic                    lock_hold;
  logic [IDX_BITS-1:0]     next_ptr;
  logic [IDX_BITS-1:0]     search_base;
  logic [2*NUM_INPUTS-1:0] req_doubled;
  logic [NUM_INPUTS-1:0]   req_rotated;
  logic                    sel_found;
  logic [IDX_BITS-1:0]     sel_offset;
  logic [IDX_BITS:0]       sel_sum;
  logic [IDX_BITS-1:0]     sel_idx;

  assign handshake = (state == GRANT) && i_ready;

  // Pointer value that follows a normal handshake: one past the grant,
  // wrapping modulo NUM_INPUTS rather than modulo 2**IDX_BITS.
  assign next_ptr = (o_index == LAST_IDX) ? '0 : o_index + 1'b1;

  // A handshake moves the search base forward in the same cycle so that a
  // back-to-back grant already sees the advanced pointer.
  assign search_base = handshake ? next_ptr : pointer;

  // Burst lock: hold ownership only while the owner keeps requesting.
`ifdef RR_REQ_ENCODER_LOCK_EN
  assign lock_hold = i_lock && i_req[o_index];
`else
  assign lock_hold = 1'b0;
`endif

  // Rotate the requests so the search base lands at bit 0; the first set bit
  // of the rotated vector is then the distance from the base to the winner.
  assign req_doubled = {i_req, i_req} >> search_base;
  assign req_rotated = req_doubled[NUM_INPUTS-1:0];

  // Find the lowest set bit of the rotated request vector.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path leaves it unassigned, which would infer a latch.
    sel_found  = 1'b0;
    sel_offset = '0;
    for (int k = NUM_INPUTS - 1; k >= 0; k--) begin
      if (req_rotated[k]) begin
        sel_found  = 1'b1;
        sel_offset = IDX_BITS'(k);
      end
    end
  end

  // Undo the rotation: base + distance, folded back below NUM_INPUTS.
  always_comb begin
    sel_sum = {1'b0, search_base} + {1'b0, sel_offset};
    if (sel_sum >= N_WIDE) begin
      sel_sum = sel_sum - N_WIDE;
    end
    sel_idx = sel_sum[IDX_BITS-1:0];
  end

  // Grant FSM with registered index, one-hot grant, valid and pointer.
  always_ff @(posedge i_clk) begin
    // NOTE: synchronous reset, so it is tested inside the clocked block and
    // wins over any handshake in the same cycle. State registers use
    // non-blocking assignment so every register samples pre-edge values.
    if (i_rst) begin
      state   <= IDLE;
      o_valid <= 1'b0;
      o_index <= '0;
      o_grant <= '0;
      pointer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_enable && sel_found) begin
            state   <= GRANT;
            o_valid <= 1'b1;
            o_index <= sel_idx;
            o_grant <= NUM_INPUTS'(1) << sel_idx;
          end
        end
        GRANT: begin
          // Without i_ready the grant is held regardless of i_req/i_enable.
          if (i_ready && !lock_hold) begin
            pointer <= next_ptr;
            if (i_enable && sel_found) begin
              o_index <= sel_idx;
              o_grant <= NUM_INPUTS'(1) << sel_idx;
            end else begin
              state   <= IDLE;
              o_valid <= 1'b0;
              o_grant <= '0;
            end
          end
        end
        default: begin
          state   <= IDLE;
          o_valid <= 1'b0;
          o_grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rr_req_encoder.sv
// ---------------------------------------------------------------------------
// tb_rr_req_encoder
//   Directed steps followed by random traffic. Every cycle the DUT outputs
//   are compared with a behavioural model that tracks grant ownership and the
//   round-robin pointer using modulo arithmetic.
// ---------------------------------------------------------------------------
module tb_rr_req_encoder;

  localparam int N  = 5;
  localparam int IB = $clog2(N);

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [N-1:0]  i_req;
  logic          i_enable;
  logic          i_ready;
  logic          i_lock;
  logic          o_valid;
  logic [IB-1:0] o_index;
  logic [N-1:0]  o_grant;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state.
  bit m_valid;
  int m_idx;
  int m_ptr;

  rr_req_encoder #(.NUM_INPUTS(N)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_req    (i_req),
    .i_enable (i_enable),
    .i_ready  (i_ready),
`ifdef RR_REQ_ENCODER_LOCK_EN
    .i_lock   (i_lock),
`endif
    .o_valid  (o_valid),
    .o_index  (o_index),
    .o_grant  (o_grant)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic bit req_bit(input logic [N-1:0] r, input int k);
    logic [N-1:0] s;
    s = r >> k;
    return s[0];
  endfunction

  // First requester at or after p, going round the ring.
  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (req_bit(r, (p + k) % N)) return (p + k) % N;
    end
    return -1;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    bit lk;
`ifdef RR_REQ_ENCODER_LOCK_EN
    lk = i_lock;
`else
    lk = 1'b0;
`endif
    if (i_rst) begin
      m_valid = 0; m_idx = 0; m_ptr = 0;
    end else if (!m_valid) begin
      if (i_enable && i_req != '0) begin
        m_valid = 1; m_idx = pick(i_req, m_ptr);
      end
    end else if (i_ready) begin
      if (!(lk && req_bit(i_req, m_idx))) begin
        m_ptr = (m_idx + 1) % N;
        if (i_enable && i_req != '0) m_idx = pick(i_req, m_ptr);
        else m_valid = 0;
      end
    end
  endtask

  // One clock: update model, wait for the edge, sample 1 ns later, compare.
  task automatic cyc(input string tag);
    logic [N-1:0] exp_grant;
    model_edge();
    @(posedge i_clk);
    #1;
    exp_grant = m_valid ? (N'(1) << m_idx) : '0;
    check({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
    check({tag, ".index"}, 32'(o_index), 32'(m_idx));
    check({tag, ".grant"}, 32'(o_grant), 32'(exp_grant));
  endtask

  task automatic do_reset();
    i_rst = 1; i_req = '0; i_enable = 0; i_ready = 0; i_lock = 0;
    cyc("rst");
    i_rst = 0;
  endtask

  initial begin
    m_valid = 0; m_idx = 0; m_ptr = 0;
    i_rst = 1; i_req = '0; i_enable = 0; i_ready = 0; i_lock = 0;

    // Reset state, then idle requests with stray i_ready pulses.
    do_reset();
    check("reset_valid", 32'(o_valid), 32'd0);
    check("reset_index", 32'(o_index), 32'd0);
    check("reset_grant", 32'(o_grant), 32'd0);
    i_enable = 1;
    for (int i = 0; i < 5; i++) begin
      i_ready = i[0];
      cyc("idle_noreq");
      check("idle_noreq_valid", 32'(o_valid), 32'd0);
      check("idle_noreq_grant", 32'(o_grant), 32'd0);
    end

    // Single grant with 1-cycle latency, then sticky while requests vanish.
    do_reset();
    i_req = 5'b10100; i_enable = 1; i_ready = 0;
    cyc("first_grant");
    check("first_grant_valid", 32'(o_valid), 32'd1);
    check("first_grant_index", 32'(o_index), 32'd2);
    check("first_grant_onehot", 32'(o_grant), 32'h04);
    i_req = '0;
    for (int i = 0; i < 3; i++) begin
      cyc("sticky");
      check("sticky_index", 32'(o_index), 32'd2);
      check("sticky_valid", 32'(o_valid), 32'd1);
    end
    i_enable = 0;
    cyc("sticky_noen");
    check("sticky_noen_index", 32'(o_index), 32'd2);

    // All requesting with continuous ready: 0,1,2,3,4,0 with no bubble.
    do_reset();
    i_req = 5'b11111; i_enable = 1; i_ready = 1;
    for (int i = 0; i < 6; i++) begin
      cyc("rotate");
      check("rotate_index", 32'(o_index), 32'(i % N));
      check("rotate_valid", 32'(o_valid), 32'd1);
    end

    // Pointer=4 with requests 1,2 wraps to 1; pointer=2 with request 0 wraps to 0.
    do_reset();
    i_req = 5'b01000; i_enable = 1; i_ready = 0;
    cyc("ptr_setup3");
    i_enable = 0; i_ready = 1;
    cyc("ptr_hs3");
    i_req = 5'b00110; i_enable = 1; i_ready = 0;
    cyc("wrap_ptr4");
    check("wrap_ptr4_index", 32'(o_index), 32'd1);
    i_enable = 0; i_ready = 1;
    cyc("ptr_hs1");
    i_req = 5'b00001; i_enable = 1; i_ready = 0;
    cyc("wrap_ptr2");
    check("wrap_ptr2_index", 32'(o_index), 32'd0);

    // Reset coinciding with a handshake on index 3 drops it, pointer back to 0.
    do_reset();
    i_req = 5'b01000; i_enable = 1; i_ready = 0;
    cyc("rst_hs_setup");
    check("rst_hs_setup_index", 32'(o_index), 32'd3);
    i_ready = 1; i_rst = 1;
    cyc("rst_hs");
    check("rst_hs_valid", 32'(o_valid), 32'd0);
    check("rst_hs_index", 32'(o_index), 32'd0);
    i_rst = 0; i_ready = 0; i_req = 5'b01001;
    cyc("rst_hs_after");
    check("rst_hs_after_index", 32'(o_index), 32'd0);

`ifdef RR_REQ_ENCODER_LOCK_EN
    // Burst lock keeps index 1 across handshakes, unlocking moves on to 3.
    do_reset();
    i_req = 5'b01010; i_enable = 1; i_ready = 0;
    cyc("lock_setup");
    check("lock_setup_index", 32'(o_index), 32'd1);
    i_lock = 1; i_ready = 1;
    for (int i = 0; i < 3; i++) begin
      cyc("lock_hold");
      check("lock_hold_index", 32'(o_index), 32'd1);
    end
    i_lock = 0;
    cyc("lock_release");
    check("lock_release_index", 32'(o_index), 32'd3);
    i_ready = 0;
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      i_rst    = ($urandom_range(0, 49) == 0);
      i_req    = N'($urandom);
      if ($urandom_range(0, 3) == 0) i_req = '0;
      i_enable = ($urandom_range(0, 4) != 0);
      i_ready  = ($urandom_range(0, 2) != 0);
      i_lock   = ($urandom_range(0, 2) == 0);
      cyc("random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_req_encoder.md
Name: rr_req_encoder

Overview:
- Round-robin request encoder: collapses a vector of request lines into one registered binary index plus a valid/ready handshake toward a single consumer.
- Inverse of the select-to-one-hot demux. Its index output drives that demux's select where N requesters share one resource.
- Fairness is by a rotating priority pointer. A grant is held stable until the consumer accepts it.

Parameters:
- NUM_INPUTS, 5, number of request lines; any value >= 2, need not be a power of two.
- IDX_BITS, $clog2(NUM_INPUTS), localparam; width of the index and of the pointer.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_req  input  NUM_INPUTS  request lines; bit k = requester k.
- i_enable  input  1  permits new grants; does not affect a grant already issued.
- i_ready  input  1  consumer accepts the current grant.
- o_valid  output  1  grant present.
- o_index  output  IDX_BITS  encoded granted requester; meaningful only while o_valid=1.
- o_grant  output  NUM_INPUTS  one-hot of o_index while o_valid=1, else all zeros.

Behaviour:
- Reset (i_rst=1 at an edge): state=IDLE, o_valid=0, o_index=0, o_grant=0, pointer=0. Reset overrides everything, including a pending grant or handshake in the same cycle; the grant is dropped and not accepted.
- FSM has two states: IDLE and GRANT. o_valid=1 exactly in GRANT.
- Selection: the first set bit of i_req searching upward from index=pointer, wrapping from NUM_INPUTS-1 to 0. Combinational, on the current i_req.
- IDLE: if i_enable=1 and i_req!=0, register the selected index into o_index and go to GRANT. Latency is 1 cycle from request to o_valid. Otherwise stay in IDLE; o_index holds its last value.
- GRANT: o_index and o_grant are held constant while i_ready=0. This holds even if i_req[o_index] drops (sticky grant) and even if i_enable drops.
- Handshake = o_valid & i_ready at an edge. On handshake:
  - pointer <= o_index+1, or 0 if o_index == NUM_INPUTS-1. Wrap is modulo NUM_INPUTS, never modulo 2^IDX_BITS.
  - Back-to-back: if i_enable=1 and i_req!=0, stay in GRANT and load a new index. Selection uses the updated pointer, i.e. searches from o_index+1 with the same wrap. No bubble cycle.
  - Otherwise go to IDLE; o_valid=0 next cycle.
- i_ready while o_valid=0: ignored.
- Requests arriving during GRANT are not queued. They are re-evaluated at the next selection.
- Single persistent requester: re-granted every handshake. Pointer wraps past it and the search returns to it.
- The pointer changes only on handshake or reset.

Optional Feature:
- Macro: RR_REQ_ENCODER_LOCK_EN.
- Defined: adds port i_lock (input, 1 bit). On a handshake with i_lock=1 and i_req[o_index]=1, the pointer is not advanced. o_index is re-granted (stays in GRANT, o_valid stays 1), giving burst ownership. If i_req[o_index]=0, the normal handshake rule applies.
- Not defined: no i_lock port; every handshake advances the pointer as above.

Test Plan (NUM_INPUTS=5):
- Reset, then i_req=5'b00000, i_enable=1 for 5 cycles -> o_valid=0, o_grant=0 throughout; i_ready pulses have no effect.
- From reset, i_req=5'b10100, i_enable=1, i_ready=0 -> 1 cycle later o_valid=1, o_index=2, o_grant=5'b00100. Then drop i_req to 0 for 3 cycles -> outputs unchanged.
- i_req=5'b11111, i_enable=1, i_ready=1 continuously -> o_index sequence 0,1,2,3,4,0 on consecutive cycles with o_valid never low (wrap at 4->0, no bubble).
- Pointer=4 with i_req=5'b00110 -> grant index 1. Pointer=2 with i_req=5'b00001 -> grant index 0. Searches wrap past 4 to 0.
- In GRANT with o_index=3, i_ready=1 and i_rst=1 in the same cycle -> next cycle o_valid=0, o_index=0. A following grant with i_req=5'b01001 gives index 0 (pointer reset, not advanced).
- RR_REQ_ENCODER_LOCK_EN defined, i_req=5'b01010, granted index 1, i_lock=1, i_ready=1 for 3 cycles -> o_index stays 1. Then i_lock=0 with one handshake -> o_index=3.
